// File: rtl/reg_wport_arbiter_pkg.sv
// Shared types and constants for the register write-port arbiter.
// Holds the state encoding, the default data width and the pointer width.
package reg_wport_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam int DEF_W = 32;
    localparam int PTR_W = 3;

endpackage

// File: rtl/reg_wport_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of mask starting at ptr.
// Ports: mask[N] candidates, ptr start index, onehot[N] winner (0 if none).
module reg_wport_arbiter_rr_pick
    import reg_wport_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     mask,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     onehot
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        onehot = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            idx = IW'((int'(ptr) + k) % N);
            if (!found && mask[idx]) begin
                onehot[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_wport_arbiter.sv
// Round-robin arbiter sharing one enable-gated register write port among
// N requesters with req/ack handshake and capped locked bursts.
// Ports: clk, rst (async high), req/lock[N], wdata[N*W] in;
//        gnt/ack[N], reg_ce, reg_d[W], busy out.
module reg_wport_arbiter
    import reg_wport_arbiter_pkg::*;
#(
    parameter int N        = 4,
    parameter int W        = DEF_W,
    parameter int MAX_LOCK = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   lock,
    input  logic [N*W-1:0] wdata,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   ack,
    output logic           reg_ce,
    output logic [W-1:0]   reg_d,
    output logic           busy
);

    localparam int LW = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
    localparam logic [LW-1:0] LOCK_LAST = LW'(MAX_LOCK - 1);

    state_t           state;
    logic [PTR_W-1:0] ptr;
    logic [N-1:0]     gnt_q;
    logic [LW-1:0]    lock_cnt;

    logic [N-1:0]     pick_req;
    logic [N-1:0]     pick_rest;
    logic [N-1:0]     rest;
    logic [PTR_W-1:0] g_idx;
    logic [PTR_W-1:0] ptr_nxt;

    always_comb begin
        g_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_q[i]) g_idx = PTR_W'(i);
        end
        ptr_nxt = (int'(g_idx) == N - 1) ? '0 : g_idx + 1'b1;
    end

    // The just-served requester is excluded so its still-high req
    // in the ack cycle cannot earn a second write.
    assign rest = req & ~gnt_q;

    reg_wport_arbiter_rr_pick #(.N(N)) u_pick_idle (
        .mask   (req),
        .ptr    (ptr),
        .onehot (pick_req)
    );

    reg_wport_arbiter_rr_pick #(.N(N)) u_pick_rest (
        .mask   (rest),
        .ptr    (ptr_nxt),
        .onehot (pick_rest)
    );

    assign gnt    = gnt_q;
    assign ack    = gnt_q & req;
    assign reg_ce = |ack;
    assign busy   = (state == ST_GRANT);

    always_comb begin
        reg_d = '0;
        for (int i = 0; i < N; i++) begin
            reg_d |= wdata[i*W +: W] & {W{gnt_q[i]}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            gnt_q    <= '0;
            ptr      <= '0;
            lock_cnt <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (|req) begin
                        gnt_q    <= pick_req;
                        lock_cnt <= '0;
                        state    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (!(|ack)) begin
                        // Withdrawn: no write, keep ptr, re-arbitrate.
                        gnt_q    <= pick_req;
                        lock_cnt <= '0;
                        state    <= (|req) ? ST_GRANT : ST_IDLE;
                    end else if ((|(lock & gnt_q)) &&
                                 (lock_cnt < LOCK_LAST)) begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end else begin
                        ptr      <= ptr_nxt;
                        lock_cnt <= '0;
                        if (|rest) begin
                            gnt_q <= pick_rest;
                        end else begin
                            gnt_q <= '0;
                            state <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule
